// File: rtl/onehot_index.sv
`default_nettype none
// ============================================================================
// Module   : onehot_index
// Purpose  : Combinational one-hot to binary index converter with a
//            one-hot legality flag. Reusable by any one-hot consumer.
// Ports    : code      - NR_KEY-bit candidate one-hot code
//            index     - binary position of the set bit (meaningful only
//                        when is_onehot is 1)
//            is_onehot - 1 when exactly one bit of code is set
// Revision : 1.0 - initial release
// ============================================================================
module onehot_index #(
  parameter int NR_KEY    = 2,
  parameter int IDX_WIDTH = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
  input  logic [NR_KEY-1:0]    code,
  output logic [IDX_WIDTH-1:0] index,
  output logic                 is_onehot
);

  // OR-reduction encoder: for a legal code exactly one term contributes, so
  // no priority chain is needed. Multi-hot codes give a garbage index, which
  // the consumer must qualify with is_onehot.
  always_comb begin
    index = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (code[i]) begin
        index = index | IDX_WIDTH'(i);
      end
    end
  end

  // Non-zero with its lowest set bit being the only set bit.
  assign is_onehot = (code != '0) && ((code & (code - NR_KEY'(1))) == '0);

endmodule
`default_nettype wire

// File: rtl/onehot_key_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_key_decoder
// Purpose  : Registered single-stage decoder mapping a one-hot code to the
//            key stored at the set bit's index in a packed key table, with
//            valid/ready handshakes on both sides and a saturating count of
//            illegal (zero-hot or multi-hot) codes.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid/in_ready    - upstream handshake
//            in_code              - NR_KEY-bit one-hot code
//            keys                 - packed table, entry i at [KEY_WIDTH*i +:]
//            out_valid/out_ready  - downstream handshake
//            out_key, out_err     - decoded key and illegal-code flag
//            clr_err              - synchronous clear of err_cnt
//            err_cnt              - saturating illegal-code count
// Revision : 1.0 - initial release
// ============================================================================
module onehot_key_decoder #(
  parameter int                     NR_KEY    = 2,
  parameter int                     KEY_WIDTH = 1,
  parameter logic [KEY_WIDTH-1:0]   DEF_KEY   = '0,
  parameter int                     CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NR_KEY-1:0]           in_code,
  input  logic [NR_KEY*KEY_WIDTH-1:0] keys,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [KEY_WIDTH-1:0]        out_key,
  output logic                        out_err,
  input  logic                        clr_err,
  output logic [CNT_WIDTH-1:0]        err_cnt
);

  localparam int IDX_WIDTH = (NR_KEY > 1) ? $clog2(NR_KEY) : 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  accept;
  logic                  pop;
  logic                  illegal_accept;
  logic [IDX_WIDTH-1:0]  code_idx;
  logic                  code_onehot;
  logic [KEY_WIDTH-1:0]  sel_key;
  logic [CNT_WIDTH-1:0]  err_cnt_nxt;

  onehot_index #(
    .NR_KEY    (NR_KEY),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_onehot_index (
    .code      (in_code),
    .index     (code_idx),
    .is_onehot (code_onehot)
  );

  // A full stage that drains this cycle can take a new code, giving
  // back-to-back throughput without a skid buffer.
  assign out_valid      = (state == S_FULL);
  assign in_ready       = !out_valid || out_ready;
  assign accept         = in_valid && in_ready;
  assign pop            = out_valid && out_ready;
  assign illegal_accept = accept && !code_onehot;

  // Table lookup with constant slices only; the index is in range whenever
  // the code is legal, and illegal codes fall back to DEF_KEY.
  always_comb begin
    sel_key = DEF_KEY;
    if (code_onehot) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (code_idx == IDX_WIDTH'(i)) begin
          sel_key = keys[KEY_WIDTH*i +: KEY_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_EMPTY: if (accept)       state_nxt = S_FULL;
      S_FULL:  if (pop && !accept) state_nxt = S_EMPTY;
      default:                   state_nxt = S_EMPTY;
    endcase
  end

  // A clear coinciding with an illegal accept counts that accept, so the
  // event is not lost across the clear.
  always_comb begin
    err_cnt_nxt = err_cnt;
    if (clr_err) begin
      err_cnt_nxt = illegal_accept ? CNT_WIDTH'(1) : '0;
    end else if (illegal_accept && (err_cnt != {CNT_WIDTH{1'b1}})) begin
      err_cnt_nxt = err_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      out_key <= DEF_KEY;
      out_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      err_cnt <= err_cnt_nxt;
      // keys is sampled only here, so a held result is immune to table edits.
      if (accept) begin
        out_key <= sel_key;
        out_err <= !code_onehot;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/onehot_key_decoder.md
Name: onehot_key_decoder

Overview:
- Inverse of the one-hot encoder: takes an NR_KEY-bit one-hot code and returns the KEY_WIDTH-bit key stored at the set bit's index in a packed key table.
- Registered single-stage pipeline with valid/ready handshakes on both sides, so it can sit between decode/dispatch stages.
- Flags codes that are not one-hot (zero-hot or multi-hot) and keeps a saturating error count.

Parameters:
- NR_KEY, 2, number of table entries and width of the one-hot code.
- KEY_WIDTH, 1, width of each key.
- DEF_KEY, 0, key emitted for an illegal code.
- CNT_WIDTH, 8, width of the error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  block can accept this cycle.
- in_code  input  NR_KEY  one-hot code; bit i selects entry i.
- keys  input  NR_KEY*KEY_WIDTH  key table; entry i is keys[KEY_WIDTH*i +: KEY_WIDTH]; quasi-static.
- out_valid  output  1  out_key/out_err hold a result.
- out_ready  input  1  downstream accepts.
- out_key  output  KEY_WIDTH  decoded key.
- out_err  output  1  result came from an illegal code.
- clr_err  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_WIDTH  saturating count of illegal codes accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_key=DEF_KEY, out_err=0, err_cnt=0.
  - Any held result is discarded.
- in_ready = !out_valid || out_ready. This is combinational: a full stage drained in the same cycle accepts a new code, giving back-to-back throughput of 1 per cycle.
- Accept: in_valid && in_ready. On accept, the next out_valid is 1.
- Pop with no accept: out_valid && out_ready && !(in_valid && in_ready). The next out_valid is 0.
- Otherwise out_valid, out_key and out_err hold.
- Output stability: while out_valid=1 and out_ready=0, out_key and out_err must not change, including when keys changes.
- Latency: 1 cycle. The code accepted at edge N is visible on out_* after edge N.
- Decode on accept:
  - popcount(in_code)==1 with set bit i → out_key=entry i, out_err=0.
  - popcount 0 or ≥2 → out_key=DEF_KEY, out_err=1.
  - No priority resolution for multi-hot codes.
- keys is sampled only on the accepting cycle.
- err_cnt, evaluated each edge:
  - clr_err=1 and illegal accept → 1.
  - clr_err=1 only → 0.
  - Illegal accept only → err_cnt+1, saturating at all-ones.
  - Otherwise hold.
- in_code and keys are ignored when there is no accept. Illegal codes never count unless accepted.
- NR_KEY=1: the code is legal only when it equals 1.
- States:
  - EMPTY (out_valid=0) → FULL on accept.
  - FULL → EMPTY on pop without accept.
  - FULL → FULL on hold, or on pop+accept.

Decomposition:
- No shared package needed. DEF_KEY and the table slicing stay local.
- One combinational sub-module, onehot_index, is natural:
  - input: NR_KEY-bit code.
  - outputs: $clog2(NR_KEY)-bit index, is_onehot.
  - Reusable by other one-hot consumers.
- The top level holds the handshake register, the key mux and the counter.

Test Plan:
All cases use NR_KEY=4, KEY_WIDTH=3, CNT_WIDTH=2, DEF_KEY=0 and keys entries 0..3 = {1,7,2,5}.
1. Legal decode: send codes 4'b0001, 0010, 0100, 1000 back-to-back with out_ready=1 → out_key 1,7,2,5 on consecutive cycles; out_err=0; in_ready stays 1; err_cnt=0.
2. Backpressure: accept 4'b0100 with out_ready=0 and in_valid=1 held, change keys entry 2 to 6 → out_key stays 2 and in_ready=0 until out_ready=1. The next code 4'b0100 then yields 6.
3. Illegal codes: send 4'b0000, 4'b0110, 4'b1111, 4'b1010 → each out_key=0, out_err=1; err_cnt reads 1, 2, 3, 3 (saturated).
4. Error clear: with err_cnt=3, assert clr_err alone → 0. Assert clr_err together with accepting 4'b0011 → err_cnt=1.
5. Reset mid-operation: with out_valid=1 holding key 7 and out_ready=0, pull rst_n low between edges → out_valid=0, out_key=0 and err_cnt=0 immediately. After release the first accept of 4'b1000 gives out_key=5 one cycle later.
6. Bubbles: toggle in_valid 1/0 with out_ready=1 → out_valid follows in_valid delayed by one cycle; no duplicate outputs.
